// File: rtl/cla_pkg.sv
// Shared constants and helpers for the two-level carry-lookahead adder.
package cla_pkg;

    localparam int GROUP_W = 4;

    function automatic int num_groups(input int width);
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_block4.sv
// 4-bit lookahead group: flat sum-of-products carries plus group P/G.
module cla_block4
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       p_grp,
    output logic       g_grp
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);

    assign s = p ^ c;

    assign p_grp = &p;
    assign g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder built from 4-bit groups.
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             P_all,
    output logic             G_all,
    output logic             out_valid
);

    localparam int NG = num_groups(WIDTH);

    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic [NG:0]      gc;
    logic [WIDTH-1:0] s_comb;
    logic             g_comb;

    // Carry out of group 'upto': each term is a flat AND of group signals.
    function automatic logic la_carry(
        input logic [NG-1:0] p,
        input logic [NG-1:0] g,
        input logic          c0,
        input int            upto
    );
        logic acc;
        logic term;
        acc = 1'b0;
        for (int k = 0; k <= upto; k++) begin
            term = g[k];
            for (int m = k + 1; m <= upto; m++) term = term & p[m];
            acc = acc | term;
        end
        term = c0;
        for (int m = 0; m <= upto; m++) term = term & p[m];
        return acc | term;
    endfunction

    always_comb begin
        gc = '0;
        gc[0] = Cin;
        for (int j = 0; j < NG; j++) gc[j+1] = la_carry(gp, gg, Cin, j);
    end

    assign g_comb = la_carry(gp, gg, 1'b0, NG - 1);

    for (genvar j = 0; j < NG; j++) begin : g_grp
        cla_block4 u_blk (
            .a     (A[j*GROUP_W +: GROUP_W]),
            .b     (B[j*GROUP_W +: GROUP_W]),
            .c_in  (gc[j]),
            .s     (s_comb[j*GROUP_W +: GROUP_W]),
            .p_grp (gp[j]),
            .g_grp (gg[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum       <= '0;
            Cout      <= 1'b0;
            P_all     <= 1'b0;
            G_all     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum   <= s_comb;
                Cout  <= gc[NG];
                P_all <= &gp;
                G_all <= g_comb;
            end
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Directed and table-driven checks for cla_adder at WIDTH=4 and WIDTH=16.
module tb_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, iv4, cout4, p4, g4, ov4;
    logic [15:0] a16, b16, sum16;
    logic        cin16, iv16, cout16, p16, g16, ov16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4),
        .in_valid(iv4), .Sum(sum4), .Cout(cout4), .P_all(p4),
        .G_all(g4), .out_valid(ov4)
    );

    cla_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .Cin(cin16),
        .in_valid(iv16), .Sum(sum16), .Cout(cout16), .P_all(p16),
        .G_all(g16), .out_valid(ov16)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       p;
        logic       g;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        p;
        logic        g;
    } vec16_t;

    vec_t   tab[9];
    vec16_t tab16[5];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tab[0] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1};
        tab[1] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
        tab[2] = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};
        tab[3] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
        tab[4] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
        tab[5] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};
        tab[6] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
        tab[7] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0};
        tab[8] = '{4'h6, 4'h3, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0};

        tab16[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tab16[1] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
        tab16[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0};
        tab16[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tab16[4] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0; iv4 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0; iv16 = 1'b0;

        #3;
        check("reset_sum", {28'd0, sum4}, 32'd0);
        check("reset_flags", {27'd0, cout4, p4, g4, ov4, ov16}, 32'd0);
        check("reset_sum16", {16'd0, sum16}, 32'd0);

        #4 rst_n = 1'b1;
        step();
        check("post_reset_ov", {31'd0, ov4}, 32'd0);

        // Table vectors, one per cycle.
        for (int i = 0; i < 9; i++) begin
            a4 = tab[i].a; b4 = tab[i].b; cin4 = tab[i].cin; iv4 = 1'b1;
            step();
            check($sformatf("tab%0d_sum", i), {28'd0, sum4}, {28'd0, tab[i].sum});
            check($sformatf("tab%0d_flags", i), {28'd0, cout4, p4, g4, ov4},
                  {28'd0, tab[i].cout, tab[i].p, tab[i].g, 1'b1});
        end

        // Exhaustive sweep, back-to-back.
        for (int x = 0; x < 512; x++) begin
            logic [4:0] e;
            a4 = x[3:0]; b4 = x[7:4]; cin4 = x[8]; iv4 = 1'b1;
            e = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
            step();
            check($sformatf("sweep_%0h_%0h_%0d", a4, b4, cin4),
                  {26'd0, ov4, cout4, sum4}, {26'd0, 1'b1, e});
        end

        // Hold: valid 3+4, then idle with A changed.
        a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0; iv4 = 1'b1;
        step();
        check("hold_first", {27'd0, ov4, sum4}, {27'd0, 1'b1, 4'h7});
        a4 = 4'h9; iv4 = 1'b0;
        step();
        check("hold_sum", {28'd0, sum4}, 32'h7);
        check("hold_ov", {31'd0, ov4}, 32'd0);
        step();
        check("hold_sum2", {28'd0, sum4}, 32'h7);

        // Reset mid-stream with in_valid held high.
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; iv4 = 1'b1;
        step();
        check("pre_rst", {27'd0, ov4, sum4}, {27'd0, 1'b1, 4'hF});
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_sum", {28'd0, sum4}, 32'd0);
        check("mid_rst_flags", {28'd0, cout4, p4, g4, ov4}, 32'd0);
        #4 rst_n = 1'b1;
        iv4 = 1'b0;
        step();
        check("rst_rel_ov", {31'd0, ov4}, 32'd0);
        check("rst_rel_sum", {27'd0, cout4, sum4}, 32'd0);
        a4 = 4'h2; b4 = 4'h5; cin4 = 1'b1; iv4 = 1'b1;
        step();
        check("rst_recap", {27'd0, ov4, sum4}, {27'd0, 1'b1, 4'h8});
        iv4 = 1'b0;

        // Wide instance.
        for (int i = 0; i < 5; i++) begin
            a16 = tab16[i].a; b16 = tab16[i].b; cin16 = tab16[i].cin;
            iv16 = 1'b1;
            step();
            check($sformatf("w16_%0d_sum", i), {16'd0, sum16}, {16'd0, tab16[i].sum});
            check($sformatf("w16_%0d_flags", i), {28'd0, cout16, p16, g16, ov16},
                  {28'd0, tab16[i].cout, tab16[i].p, tab16[i].g, 1'b1});
        end
        iv16 = 1'b0;
        step();
        check("w16_hold", {15'd0, ov16, sum16}, {15'd0, 1'b0, 16'h1000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_adder.md
CLA_ADDER -- requirements
Module: cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits; legal values are multiples of 4, from 4 to 32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port A, input, WIDTH bits: addend A, unsigned.
REQ-005 SHALL have port B, input, WIDTH bits: addend B, unsigned.
REQ-006 SHALL have port Cin, input, 1 bit: carry-in.
REQ-007 SHALL have port in_valid, input, 1 bit: qualifies A, B and Cin in the current cycle.
REQ-008 SHALL have port Sum, output, WIDTH bits: registered sum bits.
REQ-009 SHALL have port Cout, output, 1 bit: registered carry-out.
REQ-010 SHALL have port P_all, output, 1 bit: registered block propagate, the AND of all A[i]^B[i].
REQ-011 SHALL have port G_all, output, 1 bit: registered block generate, equal to the carry-out with Cin forced to 0.
REQ-012 SHALL have port out_valid, output, 1 bit: Sum, Cout, P_all and G_all hold a new result.

Function
REQ-013 SHALL compute {Cout,Sum} = A + B + Cin, exactly (WIDTH+1)-bit unsigned, with no truncation or wrap beyond Cout.
REQ-014 SHALL derive per-bit g[i] = A[i]&B[i] and p[i] = A[i]^B[i], and Sum[i] = p[i]^c[i].
REQ-015 SHALL compute every carry c[i] by lookahead equations (c[i+1] = g[i] | p[i]&c[i], expanded in sum-of-products form within each 4-bit group), with no ripple chain inside a group.
REQ-016 SHALL combine groups through a second-level lookahead on group P/G; group carries SHALL NOT ripple for WIDTH > 4.
REQ-017 SHALL capture the result on the rising clk edge when in_valid=1; latency is exactly 1 cycle.
REQ-018 SHALL set out_valid to in_valid delayed by one cycle; when in_valid=0, Sum, Cout, P_all and G_all SHALL hold their previous values.
REQ-019 SHALL accept a new operand set every cycle (full throughput, no backpressure).
REQ-020 SHALL handle the boundary cases as ordinary arithmetic: all-ones + all-ones + 1 gives Cout=1 and Sum = all-ones; all-ones + 0 + 1 gives Cout=1 and Sum = 0.
REQ-021 SHALL produce no X on any output for known inputs after reset is released.

Reset
REQ-022 SHALL, while rst_n=0, immediately clear Sum=0, Cout=0, P_all=0, G_all=0 and out_valid=0, independent of clk.
REQ-023 SHALL abandon any pending capture when rst_n is asserted, and SHALL NOT raise out_valid in the first cycle after reset release unless in_valid=1 at that edge.
REQ-024 SHALL release reset synchronously to clk: the first capture occurs on the first rising edge at which rst_n=1.

Structure
REQ-025 SHALL place the constant GROUP_W=4 in the shared package cla_pkg.
REQ-026 SHALL place the group-count helper function (WIDTH/GROUP_W) in cla_pkg.
REQ-027 SHALL implement each 4-bit group as the sub-module cla_block4 (ports a[3:0], b[3:0], c_in; outputs s[3:0], p_grp, g_grp), instantiated WIDTH/4 times by generate.
REQ-028 SHALL implement the second-level lookahead and the output registers in cla_adder itself.

Verification
REQ-029 A bench SHALL cover exhaustive sweep, WIDTH=4: all 16x16x2 combinations of A, B, Cin, each with in_valid=1 -> one cycle later, {Cout,Sum} equals A+B+Cin.
REQ-030 A bench SHALL cover A=4'hF, B=4'hF, Cin=1 -> Sum=4'hF, Cout=1, P_all=0, G_all=1.
REQ-031 A bench SHALL cover A=4'hA, B=4'h5, Cin=1 -> Sum=4'h0, Cout=1, P_all=1, G_all=0.
REQ-032 A bench SHALL cover hold behaviour: result from A=3, B=4, Cin=0, then in_valid=0 with A=9 applied -> Sum stays 4'h7 and out_valid=0.
REQ-033 A bench SHALL cover reset mid-stream: rst_n pulsed low between clk edges after a valid result -> all outputs 0 immediately, out_valid=0 until the next valid capture.
REQ-034 A bench SHALL cover WIDTH=16: A=16'hFFFF, B=16'h0001, Cin=0 -> Sum=16'h0000, Cout=1.
